// File: rtl/synth_param_bus_master.sv
// Parameter-bus initiator: turns queued write/read commands into SETUP/STROBE/HOLD bus cycles and returns read bytes.
// Latency: an op occupies SETUP_CYC+STROBE_CYC+HOLD_CYC cycles; read data pulses on rsp_valid the cycle after HOLD.
// Backpressure: cmd_ready is high only in IDLE with no dump active or pending; responses have no backpressure.
// Optional feature macro PARAM_DUMP_EN: sequenced read-back of every osc and common register.
module synth_param_bus_master #(
    parameter int V_OSC      = 4,
    parameter int COM_ADRS   = 16,
    parameter int SETUP_CYC  = 2,
    parameter int STROBE_CYC = 2,
    parameter int HOLD_CYC   = 1
) (
    input  logic       sCLK_XVXOSC,
    input  logic       reset,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       cmd_wr,
    input  logic       cmd_sel,
    input  logic [6:0] cmd_adr,
    input  logic [7:0] cmd_data,
    output logic       rsp_valid,
    output logic       rsp_sel,
    output logic [6:0] rsp_adr,
    output logic [7:0] rsp_data,
    input  logic       dump_start,
    output logic       dump_busy,
    inout  wire  [7:0] data,
    output logic [6:0] adr,
    output logic       write,
    output logic       read,
    output logic       osc_sel,
    output logic       com_sel,
    output logic       sysex_data_patch_send
);

    localparam int PW = 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_STROBE = 2'd2,
        ST_HOLD   = 2'd3
    } state_t;

    state_t          state, state_nxt;
    logic [PW-1:0]   phase, phase_nxt;
    logic            op_done;

    // Registered command: captured once at launch, never re-read from the inputs.
    logic            op_wr;
    logic            op_sel;
    logic [6:0]      op_adr;
    logic [7:0]      op_data;

    logic            launch_cmd;
    logic            launch_dump;
    logic            launch;
    logic            dump_pending;
    logic            dump_sel;
    logic [6:0]      dump_adr;
    logic            in_op;

    assign cmd_ready  = (state == ST_IDLE) && !dump_pending && !dump_busy;
    assign launch_cmd = cmd_valid && cmd_ready;
    assign launch     = launch_cmd || launch_dump;

`ifdef PARAM_DUMP_EN
    localparam int OSC_ADRS = V_OSC * 16;
    localparam int DUMP_OPS = OSC_ADRS + COM_ADRS;
    localparam int DCW      = $clog2(DUMP_OPS + 1);

    logic           dump_busy_q;
    logic [DCW-1:0] dump_cnt;
    logic           dump_go;

    assign dump_busy   = dump_busy_q;
    // Every IDLE cycle inside a dump is the one-cycle gap before the next read.
    assign launch_dump = dump_busy_q && (state == ST_IDLE);
    // A dump starts only from a quiet IDLE; a start that collides with a command waits as pending.
    assign dump_go     = (dump_start || dump_pending) && !dump_busy_q &&
                         (state == ST_IDLE) && !launch_cmd;

    // Sweep osc space first, then the common section.
    always_comb begin
        dump_sel = 1'b0;
        dump_adr = '0;
        if (dump_cnt < DCW'(OSC_ADRS)) begin
            dump_adr = 7'(dump_cnt);
        end else begin
            dump_sel = 1'b1;
            dump_adr = 7'(dump_cnt - DCW'(OSC_ADRS));
        end
    end

    // Dump sequencing: pending capture, busy flag and launched-op counter.
    always_ff @(posedge sCLK_XVXOSC or posedge reset) begin
        if (reset) begin
            dump_busy_q  <= 1'b0;
            dump_pending <= 1'b0;
            dump_cnt     <= '0;
        end else begin
            if (dump_go) begin
                dump_busy_q  <= 1'b1;
                dump_pending <= 1'b0;
            end else if (dump_start && !dump_busy_q) begin
                dump_pending <= 1'b1;
            end
            if (launch_dump) begin
                dump_cnt <= dump_cnt + 1'b1;
            end else if (op_done && dump_busy_q && (dump_cnt == DCW'(DUMP_OPS))) begin
                // Falls together with the final rsp_valid.
                dump_busy_q <= 1'b0;
                dump_cnt    <= '0;
            end
        end
    end
`else
    logic unused_dump_start;
    assign unused_dump_start = dump_start;
    assign dump_busy    = 1'b0;
    assign dump_pending = 1'b0;
    assign launch_dump  = 1'b0;
    assign dump_sel     = 1'b0;
    assign dump_adr     = '0;
`endif

    // FSM state and phase-counter register.
    always_ff @(posedge sCLK_XVXOSC or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
            phase <= '0;
        end else begin
            state <= state_nxt;
            phase <= phase_nxt;
        end
    end

    // Next-state: each bus phase lasts its configured number of cycles.
    always_comb begin
        state_nxt = state;
        phase_nxt = phase;
        op_done   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (launch) begin
                    state_nxt = ST_SETUP;
                    phase_nxt = '0;
                end
            end
            ST_SETUP: begin
                if (phase == PW'(SETUP_CYC - 1)) begin
                    state_nxt = ST_STROBE;
                    phase_nxt = '0;
                end else begin
                    phase_nxt = phase + 1'b1;
                end
            end
            ST_STROBE: begin
                if (phase == PW'(STROBE_CYC - 1)) begin
                    state_nxt = ST_HOLD;
                    phase_nxt = '0;
                end else begin
                    phase_nxt = phase + 1'b1;
                end
            end
            ST_HOLD: begin
                if (phase == PW'(HOLD_CYC - 1)) begin
                    state_nxt = ST_IDLE;
                    phase_nxt = '0;
                    op_done   = 1'b1;
                end else begin
                    phase_nxt = phase + 1'b1;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                phase_nxt = '0;
            end
        endcase
    end

    // Capture the operation at launch from either the command port or the dump sweep.
    always_ff @(posedge sCLK_XVXOSC or posedge reset) begin
        if (reset) begin
            op_wr   <= 1'b0;
            op_sel  <= 1'b0;
            op_adr  <= '0;
            op_data <= '0;
        end else if (launch_cmd) begin
            op_wr   <= cmd_wr;
            op_sel  <= cmd_sel;
            op_adr  <= cmd_adr;
            op_data <= cmd_data;
        end else if (launch_dump) begin
            op_wr   <= 1'b0;
            op_sel  <= dump_sel;
            op_adr  <= dump_adr;
            op_data <= '0;
        end
    end

    // Read data is sampled on the last HOLD edge; rsp_* then hold until the next read.
    always_ff @(posedge sCLK_XVXOSC or posedge reset) begin
        if (reset) begin
            rsp_valid <= 1'b0;
            rsp_sel   <= 1'b0;
            rsp_adr   <= '0;
            rsp_data  <= '0;
        end else begin
            rsp_valid <= op_done && !op_wr;
            if (op_done && !op_wr) begin
                rsp_sel  <= op_sel;
                rsp_adr  <= op_adr;
                rsp_data <= data;
            end
        end
    end

    // Bus outputs decode straight from state so an async reset drops them at once.
    // Data drive and patch_send come from opposite values of op_wr and can never overlap.
    assign in_op                 = (state != ST_IDLE);
    assign adr                   = in_op ? op_adr : 7'd0;
    assign osc_sel               = in_op && !op_sel;
    assign com_sel               = in_op && op_sel;
    assign write                 = op_wr && (state == ST_STROBE);
    assign read                  = !op_wr && (state == ST_STROBE);
    assign sysex_data_patch_send = in_op && !op_wr;
    assign data                  = (in_op && op_wr) ? op_data : 8'bz;

endmodule
